load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- MEM-stage load/store sequencer between the EX/MEM pipeline register and data_memory.
- Turns byte-addressed byte/half/word requests into word-indexed data_memory accesses; the memory has a 1-cycle registered read.
- Sub-word stores run as read-modify-write; loads are extracted and sign/zero-extended.
- Stalls the pipeline while a multi-cycle access is in flight.

Parameters:
- DEPTH_WORDS, 11, number of words in data_memory (valid word indices 0..DEPTH_WORDS-1).
- MSB, 31, data/address MSB.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present in EX/MEM.
- req_rd  in  1  load request.
- req_wr  in  1  store request.
- req_size  in  2  00 byte, 01 half, 10 word; 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; sub-word data sits in the low bits.
- stall  out  1  hold the pipeline; the request must stay stable while high.
- load_valid  out  1  load_data is valid this cycle.
- load_data  out  32  extended load result.
- err  out  1  one-cycle pulse: request rejected, no memory access made.
- err_code  out  2  01 misaligned, 10 out of range, 11 illegal (rd&wr or size 11); valid with err.
- mem_rd  out  1  to data_memory Rd.
- mem_wr  out  1  to data_memory Wr.
- mem_addr  out  32  word index = byte address >> 2.
- mem_wr_data  out  32  to data_memory wr_data.
- mem_rd_data  in  32  from data_memory rd_data; valid the cycle after mem_rd.

Behaviour:
- FSM states: IDLE, LD_WAIT, RMW_WAIT.
- Reset (reset=0, asynchronous): state=IDLE, latched request cleared.
  - stall, load_valid, err, mem_rd and mem_wr are 0; load_data, err_code and mem_wr_data are 0.
  - A reset mid-operation drops the transaction; no write is issued.
- Checks in IDLE, when req_valid=1 and (req_rd or req_wr), in priority order:
  - Illegal (err_code 11): rd&wr both set, or size 11.
  - Misaligned (err_code 01): half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range (err_code 10): addr>>2 >= DEPTH_WORDS.
  - Any failing check: err=1 for that cycle, no mem_rd/mem_wr, stall=0, stay IDLE.
- IDLE, aligned word store: mem_wr=1, mem_wr_data=req_wdata, mem_addr=addr>>2, stall=0, stay IDLE. Single cycle.
- IDLE, load: mem_rd=1, stall=1. Latch addr[1:0], size and unsigned. Go to LD_WAIT.
- LD_WAIT: extract from mem_rd_data using the latched lane. load_valid=1, stall=0, go to IDLE. Load latency is 1 cycle after acceptance.
- IDLE, byte/half store: mem_rd=1, stall=1. Latch addr, size and wdata. Go to RMW_WAIT.
- RMW_WAIT:
  - mem_wr=1, mem_addr=latched word index.
  - mem_wr_data = mem_rd_data with only the target lane replaced by latched wdata[7:0] or [15:0].
  - stall=0, go to IDLE.
- Lane mapping is little-endian:
  - Byte lane k = addr[1:0] maps to bits 8k+7:8k.
  - Half lane addr[1] maps to bits 15:0 (addr[1]=0) or 31:16 (addr[1]=1).
- Extension: signed loads replicate bit 7 (byte) or bit 15 (half); unsigned loads zero-fill.
- req_valid=0, or neither rd nor wr: no access, all strobes 0.
- Requests are never accepted outside IDLE. The pipeline holds the request during stall; on the cycle stall drops, the same request is not re-accepted, because stall=0 advances the pipeline.
- mem_rd and mem_wr are never asserted in the same cycle.
- load_valid and err are single-cycle pulses.
- load_data holds its last value when load_valid=0.

Test Plan:
- Release reset, load word at byte addr 0x0 (memory resets every word to 3) -> mem_rd in the accept cycle, stall=1; next cycle load_valid=1, load_data=0x00000003.
- Store word 0x80FF7F01 to addr 0x4, then load byte signed at 0x4, 0x5, 0x6, 0x7 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; unsigned at 0x7 -> 0x00000080.
- Store byte 0xAB to addr 0x9 over word 0x00000003 -> RMW: mem_rd, then mem_wr with data 0x0000AB03 at index 2; stall high exactly 1 cycle; word load at 0x8 returns 0x0000AB03.
- Store half 0x1234 at 0x2, then signed half load at 0x2 -> memory word 0x12340003; load_data=0x00001234.
- Half store at 0x3, word load at 0x6, and word load at byte addr 44 (index 11, DEPTH_WORDS=11) -> err pulses with codes 01, 01, 10; no mem_rd/mem_wr, stall=0.
- Assert reset during RMW_WAIT of a byte store to 0xC -> no mem_wr; after release state is IDLE and a word load at 0xC returns 0x00000003. Also: req_rd=req_wr=1 -> err, err_code=11.

Source files
------------

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit: MEM-stage byte/half/word load-store sequencer in front of a
// word-indexed data memory with a 1-cycle registered read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int DEPTH_WORDS = 11,
  parameter int MSB         = 31
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_rd,
  input  logic         req_wr,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [MSB:0] req_addr,
  input  logic [MSB:0] req_wdata,
  output logic         stall,
  output logic         load_valid,
  output logic [MSB:0] load_data,
  output logic         err,
  output logic [1:0]   err_code,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [MSB:0] mem_addr,
  output logic [MSB:0] mem_wr_data,
  input  logic [MSB:0] mem_rd_data
);

  localparam int W = MSB + 1;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, LD_WAIT = 2'd1, RMW_WAIT = 2'd2} state_t;

  state_t       state;
  logic [1:0]   lat_lane;
  logic [1:0]   lat_size;
  logic         lat_uns;
  logic [MSB:0] lat_idx;
  logic [15:0]  lat_wdata;
  logic [MSB:0] load_hold;

  logic         w_req, w_illegal, w_misal, w_oor, w_bad;
  logic         w_acc_ld, w_acc_rmw;
  logic [MSB:0] w_req_idx;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;
  logic [MSB:0] w_ext;
  logic [MSB:0] w_merged;

  assign w_req     = (state == IDLE) && req_valid && (req_rd || req_wr);
  assign w_req_idx = {2'b00, req_addr[MSB:2]};
  assign w_illegal = (req_rd && req_wr) || (req_size == SZ_ILL);
  assign w_misal   = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign w_oor     = w_req_idx >= W'(DEPTH_WORDS);
  assign w_bad     = w_illegal || w_misal || w_oor;
  assign w_acc_ld  = w_req && !w_bad && req_rd;
  assign w_acc_rmw = w_req && !w_bad && req_wr && (req_size != SZ_WORD);

  // Lane extraction and sub-word merge both work on the word returned for the latched request
  assign w_byte = mem_rd_data[8*lat_lane +: 8];
  assign w_half = mem_rd_data[16*lat_lane[1] +: 16];

  always_comb begin
    w_ext = mem_rd_data;
    if (lat_size == SZ_BYTE)
      w_ext = {{(W-8){!lat_uns && w_byte[7]}}, w_byte};
    else if (lat_size == SZ_HALF)
      w_ext = {{(W-16){!lat_uns && w_half[15]}}, w_half};
  end

  always_comb begin
    w_merged = mem_rd_data;
    if (lat_size == SZ_BYTE)
      w_merged[8*lat_lane +: 8] = lat_wdata[7:0];
    else
      w_merged[16*lat_lane[1] +: 16] = lat_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_lane  <= '0;
      lat_size  <= '0;
      lat_uns   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      load_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (w_acc_ld || w_acc_rmw) begin
            lat_lane  <= req_addr[1:0];
            lat_size  <= req_size;
            lat_uns   <= req_unsigned;
            lat_idx   <= w_req_idx;
            lat_wdata <= req_wdata[15:0];
            state     <= w_acc_ld ? LD_WAIT : RMW_WAIT;
          end
        end
        LD_WAIT: begin
          load_hold <= w_ext;
          state     <= IDLE;
        end
        RMW_WAIT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall       = 1'b0;
    load_valid  = 1'b0;
    err         = 1'b0;
    err_code    = 2'b00;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = lat_idx;
    mem_wr_data = '0;
    case (state)
      IDLE: begin
        mem_addr = w_req_idx;
        if (w_req) begin
          if (w_bad) begin
            err      = 1'b1;
            err_code = w_illegal ? 2'b11 : (w_misal ? 2'b01 : 2'b10);
          end else if (req_rd || (req_size != SZ_WORD)) begin
            mem_rd = 1'b1;
            stall  = 1'b1;
          end else begin
            mem_wr      = 1'b1;
            mem_wr_data = req_wdata;
          end
        end
      end
      LD_WAIT:  load_valid = 1'b1;
      RMW_WAIT: begin
        mem_wr      = 1'b1;
        mem_wr_data = w_merged;
      end
      default: ;
    endcase
  end

  assign load_data = load_valid ? w_ext : load_hold;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit: scoreboard bench for load_store_unit with a behavioural
// data memory (every word starts at 3, 1-cycle registered read).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_load_store_unit;

  localparam int DEPTH = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_rd = 1'b0, req_wr = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, load_valid, err, mem_rd, mem_wr;
  logic [1:0]  err_code;
  logic [31:0] load_data, mem_addr, mem_wr_data;
  logic [31:0] mem_rd_data;

  logic        init_mem = 1'b1;
  logic [31:0] mem [DEPTH];
  logic [31:0] mdl [DEPTH];

  logic [31:0] exp_load_q [$];
  logic [63:0] exp_wr_q [$];
  logic [1:0]  exp_err_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH_WORDS(DEPTH), .MSB(31)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rd(req_rd), .req_wr(req_wr),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_valid(load_valid), .load_data(load_data),
    .err(err), .err_code(err_code),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // Memory is initialised once; a later DUT reset must not hide a stray write
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd3;
      mem_rd_data <= '0;
    end else begin
      if (mem_wr && mem_addr < DEPTH) mem[mem_addr[3:0]] <= mem_wr_data;
      if (mem_rd) mem_rd_data <= (mem_addr < DEPTH) ? mem[mem_addr[3:0]] : 32'hDEAD_BEEF;
    end
  end

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (mem_rd && mem_wr) check_value("rd_wr_overlap", 1, 0);
    if (load_valid) begin
      if (exp_load_q.size() == 0) check_value("unexpected_load", 1, 0);
      else check_value("load_data", load_data, exp_load_q.pop_front());
    end
    if (mem_wr) begin
      if (exp_wr_q.size() == 0) check_value("unexpected_write", {mem_addr, mem_wr_data}, 0);
      else check_value("mem_write", {mem_addr, mem_wr_data}, exp_wr_q.pop_front());
    end
    if (err) begin
      if (exp_err_q.size() == 0) check_value("unexpected_err", {62'd0, err_code}, 0);
      else check_value("err_code", {62'd0, err_code}, {62'd0, exp_err_q.pop_front()});
    end
  end

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mdl[a >> 2];
    b = w[8*a[1:0] +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    if (sz == 2'b00) return uns ? {24'd0, b} : {{24{b[7]}}, b};
    if (sz == 2'b01) return uns ? {16'd0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  // Called at posedge+1; returns at the following posedge+1 with the request withdrawn
  task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_ld,
                        input string tag);
    logic [1:0]  code;
    logic [31:0] merged;
    logic        e_stall, e_rd, e_wr;
    int          st;
    code = 2'b00;
    if ((rd && wr) || sz == 2'b11) code = 2'b11;
    else if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) code = 2'b01;
    else if ((a >> 2) >= DEPTH) code = 2'b10;
    e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
    if (code != 2'b00) begin
      exp_err_q.push_back(code);
    end else if (rd) begin
      exp_load_q.push_back(exp_ld);
      e_stall = 1'b1; e_rd = 1'b1;
    end else begin
      merged = mdl[a >> 2];
      if (sz == 2'b10) begin
        merged = wd; e_wr = 1'b1;
      end else begin
        if (sz == 2'b00) merged[8*a[1:0] +: 8] = wd[7:0];
        else if (a[1]) merged[31:16] = wd[15:0];
        else merged[15:0] = wd[15:0];
        e_stall = 1'b1; e_rd = 1'b1;
      end
      mdl[a >> 2] = merged;
      exp_wr_q.push_back({a >> 2, merged});
    end
    req_valid = 1'b1; req_rd = rd; req_wr = wr; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    @(negedge clk);
    check_value({tag, "_mem_rd"}, mem_rd, e_rd);
    check_value({tag, "_err"}, err, code != 2'b00);
    if (e_rd) check_value({tag, "_rd_addr"}, mem_addr, a >> 2);
    if (!e_rd) check_value({tag, "_mem_wr"}, mem_wr, e_wr);
    st = 0;
    while (stall && st < 8) begin
      st++;
      @(negedge clk);
    end
    check_value({tag, "_stall_cycles"}, st, e_stall ? 1 : 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_stall", stall, 0);
    check_value("rst_load_valid", load_valid, 0);
    check_value("rst_err", err, 0);
    check_value("rst_mem_rd", mem_rd, 0);
    check_value("rst_mem_wr", mem_wr, 0);
    check_value("rst_load_data", load_data, 0);
    check_value("rst_err_code", err_code, 0);
    check_value("rst_mem_wr_data", mem_wr_data, 0);
    init_mem = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    do_req(1, 0, 2'b10, 0, 32'h0, 0, 32'h0000_0003, "ld_w0");
    do_req(0, 1, 2'b10, 0, 32'h4, 32'h80FF_7F01, 0, "st_w4");
    do_req(1, 0, 2'b00, 0, 32'h4, 0, 32'h0000_0001, "ld_b4");
    do_req(1, 0, 2'b00, 0, 32'h5, 0, 32'h0000_007F, "ld_b5");
    do_req(1, 0, 2'b00, 0, 32'h6, 0, 32'hFFFF_FFFF, "ld_b6");
    do_req(1, 0, 2'b00, 0, 32'h7, 0, 32'hFFFF_FF80, "ld_b7");
    do_req(1, 0, 2'b00, 1, 32'h7, 0, 32'h0000_0080, "ld_bu7");
    // load_data must hold between loads
    @(negedge clk);
    check_value("load_hold", load_data, 32'h0000_0080);
    @(posedge clk); #1;
    do_req(0, 1, 2'b00, 0, 32'h9, 32'h0000_00AB, 0, "st_b9");
    do_req(1, 0, 2'b10, 0, 32'h8, 0, 32'h0000_AB03, "ld_w8");
    do_req(0, 1, 2'b01, 0, 32'h2, 32'h0000_1234, 0, "st_h2");
    do_req(1, 0, 2'b01, 0, 32'h2, 0, 32'h0000_1234, "ld_h2");
    do_req(1, 0, 2'b10, 0, 32'h0, 0, 32'h1234_0003, "ld_w0b");
    do_req(0, 1, 2'b01, 0, 32'h3, 32'h5555, 0, "err_h3");
    do_req(1, 0, 2'b10, 0, 32'h6, 0, 0, "err_w6");
    do_req(1, 0, 2'b10, 0, 32'd44, 0, 0, "err_w44");
    do_req(1, 1, 2'b10, 0, 32'h0, 0, 0, "err_rdwr");
    do_req(1, 0, 2'b11, 0, 32'h0, 0, 0, "err_sz3");
    do_req(0, 1, 2'b10, 0, 32'd40, 32'hCAFE_F00D, 0, "st_w40");
    do_req(1, 0, 2'b01, 1, 32'd42, 0, 32'h0000_CAFE, "ld_hu42");

    // Request present but not valid: nothing happens
    req_valid = 1'b0; req_rd = 1'b1; req_addr = 32'h0;
    @(negedge clk);
    check_value("novalid_mem_rd", mem_rd, 0);
    check_value("novalid_stall", stall, 0);
    @(posedge clk); #1 req_rd = 1'b0;

    // Reset while the byte store to 0xC waits for its read data
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b00; req_addr = 32'hC; req_wdata = 32'h77;
    @(negedge clk);
    check_value("rmwrst_mem_rd", mem_rd, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0;
    @(negedge clk);
    check_value("rmwrst_mem_wr", mem_wr, 0);
    check_value("rmwrst_stall", stall, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    do_req(1, 0, 2'b10, 0, 32'hC, 0, 32'h0000_0003, "ld_wC");

    for (int i = 0; i < 12; i++) begin
      sz = 2'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 4*DEPTH-1));
      if (sz == 2'b01) a[0] = 1'b0;
      do_req(0, 1, sz, 0, a, $urandom, 0, "rnd_st");
      sz = 2'($urandom_range(0, 2));
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b10) a[1:0] = 2'b00;
      req_unsigned = 1'($urandom_range(0, 1));
      do_req(1, 0, sz, req_unsigned, a, 0, model_load(a, sz, req_unsigned), "rnd_ld");
    end

    repeat (3) @(posedge clk);
    check_value("load_q_empty", exp_load_q.size(), 0);
    check_value("wr_q_empty", exp_wr_q.size(), 0);
    check_value("err_q_empty", exp_err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
